// File: rtl/sound_pkg.sv
// Shared constants, state encoding and timing helpers for the sound sequencer.
package sound_pkg;

    localparam logic [1:0] CODE_PING = 2'd0;
    localparam logic [1:0] CODE_PONG = 2'd1;
    localparam logic [1:0] CODE_GO   = 2'd2;
    localparam logic [1:0] CODE_STOP = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NOTE1 = 2'd1,
        GAP   = 2'd2,
        NOTE2 = 2'd3
    } state_t;

    localparam int F_PING = 1000;
    localparam int F_PONG = 500;
    localparam int F_LOW  = 440;
    localparam int F_HIGH = 880;

    function automatic int ms_cycles(input int clk_hz, input int ms);
        return ms * (clk_hz / 1000);
    endfunction

    function automatic int half_period(input int clk_hz, input int freq);
        return clk_hz / (2 * freq);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // go and stop are the only two-note programs.
    function automatic logic is_two_note(input logic [1:0] code);
        return (code == CODE_GO) || (code == CODE_STOP);
    endfunction

endpackage

// File: rtl/sound_seq_tone_gen.sv
// Square-wave generator: loadable half-period down-counter with a toggling output.
module tone_gen #(
    parameter int HP_W = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            load,
    input  logic [HP_W-1:0] hp_val,
    input  logic            run,
    output logic            sq
);

    logic [HP_W-1:0] hp_reg;
    logic [HP_W-1:0] cnt_reg;
    logic            sq_reg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hp_reg  <= '0;
            cnt_reg <= '0;
            sq_reg  <= 1'b0;
        end else if (load) begin
            hp_reg  <= hp_val;
            cnt_reg <= hp_val;
            sq_reg  <= 1'b1;
        end else if (run) begin
            if (cnt_reg == '0) begin
                cnt_reg <= hp_reg;
                sq_reg  <= ~sq_reg;
            end else begin
                cnt_reg <= cnt_reg - HP_W'(1);
            end
        end else begin
            cnt_reg <= '0;
            sq_reg  <= 1'b0;
        end
    end

    assign sq = sq_reg;

endmodule

// File: rtl/sound_seq.sv
// Tone-program sequencer driving a piezo pin from numbers' code_sound/mute.
// Build option SOUND_QUEUE_EN: queue one pending program instead of preempting.
module sound_seq
    import sound_pkg::*;
#(
    parameter int CLK_HZ  = 12_000_000,
    parameter int NOTE_MS = 60,
    parameter int GAP_MS  = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] code_sound,
    input  logic       mute,
    output logic       spk,
    output logic       busy
);

    localparam int NOTE_CYC = ms_cycles(CLK_HZ, NOTE_MS);
    localparam int GAP_CYC  = ms_cycles(CLK_HZ, GAP_MS);
    localparam int HP_PING  = half_period(CLK_HZ, F_PING);
    localparam int HP_PONG  = half_period(CLK_HZ, F_PONG);
    localparam int HP_LOW   = half_period(CLK_HZ, F_LOW);
    localparam int HP_HIGH  = half_period(CLK_HZ, F_HIGH);

    localparam int DUR_W = $clog2(max2(NOTE_CYC, GAP_CYC));
    localparam int HP_W  = $clog2(max2(max2(HP_PING, HP_PONG), max2(HP_LOW, HP_HIGH)));

    localparam logic [DUR_W-1:0] NOTE_LD    = DUR_W'(NOTE_CYC - 1);
    localparam logic [DUR_W-1:0] GAP_LD     = DUR_W'(GAP_CYC - 1);
    localparam logic [HP_W-1:0]  HP_PING_LD = HP_W'(HP_PING - 1);
    localparam logic [HP_W-1:0]  HP_PONG_LD = HP_W'(HP_PONG - 1);
    localparam logic [HP_W-1:0]  HP_LOW_LD  = HP_W'(HP_LOW - 1);
    localparam logic [HP_W-1:0]  HP_HIGH_LD = HP_W'(HP_HIGH - 1);

    function automatic logic [HP_W-1:0] hp_note(input logic [1:0] code, input logic second);
        case (code)
            CODE_PING: return HP_PING_LD;
            CODE_PONG: return HP_PONG_LD;
            CODE_GO:   return second ? HP_HIGH_LD : HP_LOW_LD;
            default:   return second ? HP_LOW_LD : HP_HIGH_LD;
        endcase
    endfunction

    state_t           state_reg, state_next;
    logic [DUR_W-1:0] dur_reg, dur_next;
    logic [1:0]       code_reg, code_next;
    logic [1:0]       code_q_reg;
    logic             armed_reg;

    logic             sound_event;
    logic             end_now;
    logic             start;
    logic [1:0]       start_code;
    logic             tone_load;
    logic [HP_W-1:0]  tone_hp;
    logic             tone_run;
    logic             sq;

`ifdef SOUND_QUEUE_EN
    logic             pend_vld_reg, pend_vld_next;
    logic [1:0]       pend_code_reg, pend_code_next;
`endif

    // The arming edge loads code_q without an event, so reset never beeps.
    assign sound_event = armed_reg && (code_sound != code_q_reg);

    always_comb begin
        state_next = state_reg;
        dur_next   = dur_reg;
        code_next  = code_reg;
        tone_load  = 1'b0;
        tone_hp    = '0;
        end_now    = 1'b0;
        start      = 1'b0;
        start_code = code_sound;
`ifdef SOUND_QUEUE_EN
        pend_vld_next  = pend_vld_reg;
        pend_code_next = pend_code_reg;
`endif

        case (state_reg)
            NOTE1: begin
                if (dur_reg == '0) begin
                    if (is_two_note(code_reg)) begin
                        state_next = GAP;
                        dur_next   = GAP_LD;
                    end else begin
                        state_next = IDLE;
                        end_now    = 1'b1;
                    end
                end else begin
                    dur_next = dur_reg - DUR_W'(1);
                end
            end
            GAP: begin
                if (dur_reg == '0) begin
                    state_next = NOTE2;
                    dur_next   = NOTE_LD;
                    tone_load  = 1'b1;
                    tone_hp    = hp_note(code_reg, 1'b1);
                end else begin
                    dur_next = dur_reg - DUR_W'(1);
                end
            end
            NOTE2: begin
                if (dur_reg == '0) begin
                    state_next = IDLE;
                    end_now    = 1'b1;
                end else begin
                    dur_next = dur_reg - DUR_W'(1);
                end
            end
            default: ;
        endcase

`ifdef SOUND_QUEUE_EN
        if (sound_event) begin
            if (state_reg == IDLE || end_now) begin
                start         = 1'b1;
                pend_vld_next = 1'b0;
            end else begin
                pend_vld_next  = 1'b1;
                pend_code_next = code_sound;
            end
        end else if (end_now && pend_vld_reg) begin
            start         = 1'b1;
            start_code    = pend_code_reg;
            pend_vld_next = 1'b0;
        end
`else
        start = sound_event;
`endif

        if (start) begin
            state_next = NOTE1;
            code_next  = start_code;
            dur_next   = NOTE_LD;
            tone_load  = 1'b1;
            tone_hp    = hp_note(start_code, 1'b0);
        end

        tone_run = (state_next == NOTE1) || (state_next == NOTE2);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg  <= IDLE;
            dur_reg    <= '0;
            code_reg   <= '0;
            code_q_reg <= '0;
            armed_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            dur_reg    <= dur_next;
            code_reg   <= code_next;
            code_q_reg <= code_sound;
            armed_reg  <= 1'b1;
        end
    end

`ifdef SOUND_QUEUE_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pend_vld_reg  <= 1'b0;
            pend_code_reg <= '0;
        end else begin
            pend_vld_reg  <= pend_vld_next;
            pend_code_reg <= pend_code_next;
        end
    end
`endif

    tone_gen #(
        .HP_W(HP_W)
    ) u_tone (
        .clk    (clk),
        .clr    (clr),
        .load   (tone_load),
        .hp_val (tone_hp),
        .run    (tone_run),
        .sq     (sq)
    );

    // Mute gates only the pin; the square-wave phase keeps running underneath.
    assign spk  = sq & ~mute;
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_sound_seq.sv
// Directed bench for sound_seq at CLK_HZ=100_000 (NOTE 6000, GAP 2000 cycles).
module tb_sound_seq;

    localparam int NOTE = 6000;
    localparam int GAPC = 2000;

    typedef struct {
        string      name;
        logic [1:0] code;
        int         hp1;
        int         hp2;
        bit         two;
        int         len;
        int         m_on;
        int         m_off;
    } vec_t;

    logic       clk = 1'b0;
    logic       clr;
    logic [1:0] code_sound;
    logic       mute;
    logic       spk;
    logic       busy;

    int checks = 0;
    int errors = 0;

    vec_t vecs[4];

    always #5 clk = ~clk;

    sound_seq #(
        .CLK_HZ (100_000),
        .NOTE_MS(60),
        .GAP_MS (20)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .code_sound (code_sound),
        .mute       (mute),
        .spk        (spk),
        .busy       (busy)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end else begin
            $display("ok   %s value=%0d", nm, act);
        end
    endtask

    // Expected pin level j cycles after the detect edge of a program.
    function automatic bit model_spk(input int j, input int hp1, input int hp2, input bit two);
        if (j < NOTE) return ((j / hp1) % 2) == 0;
        if (two && j < NOTE + GAPC) return 1'b0;
        if (two && j < 2 * NOTE + GAPC) return (((j - NOTE - GAPC) / hp2) % 2) == 0;
        return 1'b0;
    endfunction

    function automatic vec_t mk(input string nm, input logic [1:0] c, input int h1, input int h2,
                                input bit tw, input int ln, input int on, input int off);
        vec_t v;
        v.name = nm; v.code = c; v.hp1 = h1; v.hp2 = h2;
        v.two = tw; v.len = ln; v.m_on = on; v.m_off = off;
        return v;
    endfunction

    // Called just after a negedge; the next posedge detects the code change.
    task automatic play(input vec_t v);
        int mism = 0;
        int busy_len = -1;
        int first_spk = 0;
        bit exp;
        code_sound = v.code;
        for (int k = 0; k <= v.len; k++) begin
            @(negedge clk);
            mute = (k >= v.m_on) && (k < v.m_off);
            #1;
            exp = mute ? 1'b0 : model_spk(k, v.hp1, v.hp2, v.two);
            if (k == 0) first_spk = int'(spk);
            if (spk !== exp) mism++;
            if (busy !== 1'b1 && busy_len < 0) busy_len = k;
        end
        mute = 1'b0;
        check({v.name, "_first_spk"}, first_spk, 1);
        check({v.name, "_wave_mismatches"}, mism, 0);
        check({v.name, "_busy_len"}, busy_len, v.len);
        check({v.name, "_idle_after"}, int'({spk, busy}), 0);
    endtask

    initial begin
        int viol;
        int mism;
        int busy_len;
        int spk_at;
        bit exp;

        vecs[0] = mk("stop", 2'd3, 56, 113, 1'b1, 2 * NOTE + GAPC, 0, 0);
        vecs[1] = mk("ping", 2'd0, 50, 0, 1'b0, NOTE, 0, 0);
        vecs[2] = mk("pong_mute", 2'd1, 100, 0, 1'b0, NOTE, 1000, 3000);
        vecs[3] = mk("go", 2'd2, 113, 56, 1'b1, 2 * NOTE + GAPC, 0, 0);

        clr = 1'b0;
        code_sound = 2'd1;
        mute = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", int'({spk, busy}), 0);

        // Arming: code held constant across reset release must stay silent.
        @(negedge clk);
        clr = 1'b1;
        viol = 0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            #1;
            if (spk !== 1'b0 || busy !== 1'b0) viol++;
        end
        check("arm_no_spurious", viol, 0);

        foreach (vecs[i]) play(vecs[i]);

        // Asynchronous reset mid-note, then re-arm with a different held code.
        code_sound = 2'd0;
        repeat (501) @(negedge clk);
        #1;
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_spk", int'(spk), 1);
        @(posedge clk);
        #2;
        clr = 1'b0;
        code_sound = 2'd3;
        #1;
        check("async_reset_drop", int'({spk, busy}), 0);
        @(negedge clk);
        clr = 1'b1;
        viol = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (spk !== 1'b0 || busy !== 1'b0) viol++;
        end
        check("rearm_no_spurious", viol, 0);

`ifdef SOUND_QUEUE_EN
        // Queue: ping runs to completion, last pending code (go) follows.
        code_sound = 2'd0;
        mism = 0; busy_len = -1; spk_at = -1;
        for (int k = 0; k <= NOTE + 2 * NOTE + GAPC; k++) begin
            @(negedge clk);
            #1;
            exp = (k < NOTE) ? model_spk(k, 50, 0, 1'b0) : model_spk(k - NOTE, 113, 56, 1'b1);
            if (spk !== exp) mism++;
            if (busy !== 1'b1 && busy_len < 0) busy_len = k;
            if (k == NOTE) spk_at = int'(spk);
            if (k == 2999) code_sound = 2'd1;
            if (k == 3999) code_sound = 2'd2;
        end
        check("queue_go_start_spk", spk_at, 1);
        check("queue_wave_mismatches", mism, 0);
        check("queue_busy_len", busy_len, NOTE + 2 * NOTE + GAPC);
`else
        // Preempt: pong restarts on the detect edge of the new code.
        code_sound = 2'd0;
        mism = 0; busy_len = -1; spk_at = -1;
        for (int k = 0; k <= 3000 + NOTE; k++) begin
            @(negedge clk);
            #1;
            exp = (k < 3000) ? model_spk(k, 50, 0, 1'b0) : model_spk(k - 3000, 100, 0, 1'b0);
            if (spk !== exp) mism++;
            if (busy !== 1'b1 && busy_len < 0) busy_len = k;
            if (k == 3000) spk_at = int'(spk);
            if (k == 2999) code_sound = 2'd1;
        end
        check("preempt_restart_spk", spk_at, 1);
        check("preempt_wave_mismatches", mism, 0);
        check("preempt_busy_len", busy_len, 3000 + NOTE);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
